// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register controller: register addresses,
// STATUS bit positions, command word field positions, FSM state codes and
// the data pattern returned for unmapped addresses.
package spi_reg_pkg;

    // Register addresses
    localparam logic [6:0] ADDR_ID      = 7'h00;
    localparam logic [6:0] ADDR_CTRL    = 7'h01;
    localparam logic [6:0] ADDR_STATUS  = 7'h02;
    localparam logic [6:0] ADDR_SAMPLE  = 7'h03;
    localparam logic [6:0] ADDR_SCRATCH = 7'h04;

    // STATUS bit indices
    localparam int STS_SAMPLE_VALID = 0;
    localparam int STS_OVERRUN      = 1;
    localparam int STS_CMD_ERR      = 2;
    localparam int STS_WDOG_TRIP    = 3;

    // Command word fields: [31] write, [30:24] address, [23:0] data
    localparam int CMD_WR_BIT = 31;
    localparam int ADDR_MSB   = 30;
    localparam int ADDR_LSB   = 24;
    localparam int DATA_MSB   = 23;

    // FSM state codes
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DECODE  = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    // Response data for an unmapped address
    localparam logic [23:0] ERR_DATA = 24'hDEAD00;

endpackage

// File: rtl/spi_reg_ctrl_wdog.sv
// Command watchdog: counts clocks while the ADC is enabled and no command
// arrives. o_Trip pulses for one cycle when the count reaches
// WDOG_CYCLES-1; the counter then restarts from 0. Only instantiated when
// SPI_WDOG_EN is defined.
module spi_reg_wdog #(
    parameter int unsigned WDOG_CYCLES = 1_000_000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_En,
    input  logic i_Kick,
    output logic o_Trip
);

    localparam int unsigned CW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A command kick takes priority over a trip in the same cycle.
    assign o_Trip = i_En && !i_Kick && (cnt_q == LAST);

    // Next count: reload on kick or trip, advance while enabled, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (i_Kick || o_Trip) begin
            cnt_d = '0;
        end else if (i_En) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command controller for the voltmeter ADC: decodes 32-bit command
// words, owns the ID/CTRL/STATUS/SAMPLE/SCRATCH registers and returns a
// response word to the SPI slave TX path two cycles after each command.
// Optional build macro SPI_WDOG_EN adds a command watchdog that disables
// the ADC and sets STATUS[3] when no command arrives for WDOG_CYCLES clocks.
//
// Handshake: i_RX_DV, o_TX_DV and i_ADC_Valid are single-cycle strobes with
// no back-pressure; the data bus beside each is valid only in the strobe
// cycle. A command strobe seen outside IDLE is dropped and flags cmd_err.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter logic [23:0] DEV_ID = 24'h180A01
`ifdef SPI_WDOG_EN
    , parameter int unsigned WDOG_CYCLES = 1_000_000
`endif
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_RX_DV,
    input  logic [31:0] i_RX_Word,
    output logic        o_TX_DV,
    output logic [31:0] o_TX_Word,
    input  logic        i_ADC_Valid,
    input  logic [23:0] i_ADC_Data,
    output logic        o_ADC_En,
    output logic [2:0]  o_ADC_Gain,
    output logic [3:0]  o_ADC_Rate,
    output logic        o_Sample_Irq,
    output logic [1:0]  o_Dbg_State
);

    logic [1:0]  state_q, state_d;
    logic [31:0] cmd_q;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [3:0]  status_q, status_d;
    logic [23:0] sample_q;
    logic [23:0] scratch_q, scratch_d;
    logic        tx_dv_q;
    logic [31:0] tx_word_q;

    logic        cmd_wr;
    logic [6:0]  cmd_addr;
    logic [23:0] cmd_wdata;
    logic        sample_rd, sts_w1c, bad_addr, rx_drop;
    logic [23:0] rsp_data;

    assign cmd_wr    = cmd_q[CMD_WR_BIT];
    assign cmd_addr  = cmd_q[ADDR_MSB:ADDR_LSB];
    assign cmd_wdata = cmd_q[DATA_MSB:0];
    assign rx_drop   = i_RX_DV && (state_q != ST_IDLE);

`ifdef SPI_WDOG_EN
    logic wdog_trip;

    spi_reg_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_En    (ctrl_q[0]),
        .i_Kick  (i_RX_DV),
        .o_Trip  (wdog_trip)
    );
`endif

    // FSM next state: one decode cycle, one respond cycle, back to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_RX_DV) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_RESPOND;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Register access decode; an SPI write to CTRL beats a watchdog trip.
    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        sample_rd = 1'b0;
        sts_w1c   = 1'b0;
        bad_addr  = 1'b0;
`ifdef SPI_WDOG_EN
        if (wdog_trip) ctrl_d[0] = 1'b0;
`endif
        if (state_q == ST_DECODE) begin
            case (cmd_addr)
                ADDR_ID:      begin end
                ADDR_CTRL:    if (cmd_wr) ctrl_d = cmd_wdata[7:0];
                ADDR_STATUS:  sts_w1c = cmd_wr;
                ADDR_SAMPLE:  sample_rd = !cmd_wr;
                ADDR_SCRATCH: if (cmd_wr) scratch_d = cmd_wdata;
                default:      bad_addr = 1'b1;
            endcase
        end
    end

    // STATUS next value: clears are applied first so a same-cycle set wins.
    always_comb begin
        status_d = status_q;
        if (sample_rd) status_d[STS_SAMPLE_VALID] = 1'b0;
        if (i_ADC_Valid) status_d[STS_SAMPLE_VALID] = 1'b1;
        if (sts_w1c && cmd_wdata[STS_OVERRUN]) status_d[STS_OVERRUN] = 1'b0;
        if (sts_w1c && cmd_wdata[STS_CMD_ERR]) status_d[STS_CMD_ERR] = 1'b0;
        if (i_ADC_Valid && status_q[STS_SAMPLE_VALID] && !sample_rd) status_d[STS_OVERRUN] = 1'b1;
        if (bad_addr || rx_drop) status_d[STS_CMD_ERR] = 1'b1;
`ifdef SPI_WDOG_EN
        if (sts_w1c && cmd_wdata[STS_WDOG_TRIP]) status_d[STS_WDOG_TRIP] = 1'b0;
        if (wdog_trip) status_d[STS_WDOG_TRIP] = 1'b1;
`else
        status_d[STS_WDOG_TRIP] = 1'b0;
`endif
    end

    // Response data: register value after the command; SAMPLE returns the
    // value held before any same-cycle capture.
    always_comb begin
        case (cmd_addr)
            ADDR_ID:      rsp_data = DEV_ID;
            ADDR_CTRL:    rsp_data = {16'h0000, ctrl_d};
            ADDR_STATUS:  rsp_data = {20'h00000, status_d};
            ADDR_SAMPLE:  rsp_data = sample_q;
            ADDR_SCRATCH: rsp_data = scratch_d;
            default:      rsp_data = ERR_DATA;
        endcase
    end

    // FSM state, command latch and response registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_word_q <= '0;
        end else begin
            state_q <= state_d;
            tx_dv_q <= (state_q == ST_DECODE);
            if (state_q == ST_IDLE && i_RX_DV) cmd_q <= i_RX_Word;
            if (state_q == ST_DECODE) tx_word_q <= {1'b0, cmd_addr, rsp_data};
        end
    end

    // Register file and sample capture.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            ctrl_q    <= '0;
            status_q  <= '0;
            sample_q  <= '0;
            scratch_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            scratch_q <= scratch_d;
            if (i_ADC_Valid) sample_q <= i_ADC_Data;
        end
    end

    assign o_TX_DV      = tx_dv_q;
    assign o_TX_Word    = tx_word_q;
    assign o_ADC_En     = ctrl_q[0];
    assign o_ADC_Gain   = ctrl_q[3:1];
    assign o_ADC_Rate   = ctrl_q[7:4];
    assign o_Sample_Irq = status_q[STS_SAMPLE_VALID];
    assign o_Dbg_State  = state_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Testbench for spi_reg_ctrl: directed vector table, randomized commands
// against a register-level reference model, plus hand-written sequences
// for dropped commands, reset during decode and (with SPI_WDOG_EN) the
// watchdog trip.
module tb_spi_reg_ctrl;

    localparam logic [23:0] DEV_ID = 24'h180A01;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        rx_dv = 1'b0;
    logic [31:0] rx_word = '0;
    logic        tx_dv;
    logic [31:0] tx_word;
    logic        adc_valid = 1'b0;
    logic [23:0] adc_data = '0;
    logic        adc_en;
    logic [2:0]  adc_gain;
    logic [3:0]  adc_rate;
    logic        irq;
    logic [1:0]  dbg_state;

    spi_reg_ctrl #(
        .DEV_ID (DEV_ID)
`ifdef SPI_WDOG_EN
        , .WDOG_CYCLES (16)
`endif
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_RX_DV      (rx_dv),
        .i_RX_Word    (rx_word),
        .o_TX_DV      (tx_dv),
        .o_TX_Word    (tx_word),
        .i_ADC_Valid  (adc_valid),
        .i_ADC_Data   (adc_data),
        .o_ADC_En     (adc_en),
        .o_ADC_Gain   (adc_gain),
        .o_ADC_Rate   (adc_rate),
        .o_Sample_Irq (irq),
        .o_Dbg_State  (dbg_state)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %08h required %08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_ctrl;
    logic [23:0] m_sample, m_scratch;
    bit          m_sv, m_ov, m_err, m_wd;

    task automatic model_reset();
        m_ctrl = '0; m_sample = '0; m_scratch = '0;
        m_sv = 0; m_ov = 0; m_err = 0; m_wd = 0;
    endtask

    task automatic model_adc(input logic [23:0] d);
        if (m_sv) m_ov = 1;
        m_sample = d;
        m_sv = 1;
    endtask

    task automatic model_cmd(input logic [31:0] cmd, input bit same, input logic [23:0] d,
                             output logic [31:0] exp);
        logic wr;
        logic [6:0] a;
        logic [23:0] wd, old_sample, data;
        bit sv_before, sample_read;
        wr = cmd[31]; a = cmd[30:24]; wd = cmd[23:0];
        old_sample = m_sample;
        sv_before = m_sv;
        sample_read = !wr && (a == 7'h03);
        case (a)
            7'h00: begin end
            7'h01: if (wr) m_ctrl = wd[7:0];
            7'h02: if (wr) begin
                if (wd[1]) m_ov = 0;
                if (wd[2]) m_err = 0;
                if (wd[3]) m_wd = 0;
            end
            7'h03: if (!wr) m_sv = 0;
            7'h04: if (wr) m_scratch = wd;
            default: m_err = 1;
        endcase
        if (same) begin
            if (sv_before && !sample_read) m_ov = 1;
            m_sample = d;
            m_sv = 1;
        end
        case (a)
            7'h00:   data = DEV_ID;
            7'h01:   data = {16'h0000, m_ctrl};
            7'h02:   data = {20'h00000, m_wd, m_err, m_ov, m_sv};
            7'h03:   data = old_sample;
            7'h04:   data = m_scratch;
            default: data = 24'hDEAD00;
        endcase
        exp = {1'b0, a, data};
    endtask

    // ---------------- driver tasks ----------------
    task automatic adc_pulse(input logic [23:0] d);
        @(posedge clk); #1;
        adc_valid = 1'b1; adc_data = d;
        @(posedge clk); #1;
        adc_valid = 1'b0;
    endtask

    // Sends one command; optionally pulses the ADC during the decode cycle.
    // Checks the response strobe rises exactly two cycles after i_RX_DV and
    // lasts one cycle.
    task automatic send_cmd(input logic [31:0] cmd, input bit same, input logic [23:0] d,
                            output logic [31:0] rsp);
        @(posedge clk); #1;
        rx_dv = 1'b1; rx_word = cmd;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        if (same) begin adc_valid = 1'b1; adc_data = d; end
        @(negedge clk);
        check("tx_dv_early", {31'd0, tx_dv}, 32'd0);
        @(posedge clk); #1;
        adc_valid = 1'b0;
        @(negedge clk);
        check("tx_dv_pulse", {31'd0, tx_dv}, 32'd1);
        rsp = tx_word;
        @(negedge clk);
        check("tx_dv_width", {31'd0, tx_dv}, 32'd0);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] ec, input bit ei);
        check({tag, "_ctrl"}, {24'd0, adc_rate, adc_gain, adc_en}, {24'd0, ec});
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, ei});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_adc;
        logic [31:0] cmd;
        bit          adc_same;
        logic [23:0] adc_d;
        logic [31:0] exp_tx;
        logic [7:0]  exp_ctrl;
        bit          exp_irq;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl[NV];

    function automatic vec_t mk(input bit is_adc, input logic [31:0] cmd, input bit same,
                                input logic [23:0] ad, input logic [31:0] etx,
                                input logic [7:0] ec, input bit ei);
        vec_t v;
        v.is_adc = is_adc; v.cmd = cmd; v.adc_same = same; v.adc_d = ad;
        v.exp_tx = etx; v.exp_ctrl = ec; v.exp_irq = ei;
        return v;
    endfunction

    initial begin
        logic [31:0] rsp, e, cmd;
        logic [23:0] wd, ad;
        logic [6:0]  a;
        bit          wr, same;
        int          n;

        tbl[0]  = mk(0, 32'h0000_0000, 0, 24'h0,      32'h0018_0A01, 8'h00, 0);
        tbl[1]  = mk(0, 32'h8100_00B5, 0, 24'h0,      32'h0100_00B5, 8'hB5, 0);
        tbl[2]  = mk(0, 32'h8100_00B4, 0, 24'h0,      32'h0100_00B4, 8'hB4, 0);
        tbl[3]  = mk(1, 32'h0,         0, 24'h123456, 32'h0,         8'hB4, 1);
        tbl[4]  = mk(0, 32'h0300_0000, 0, 24'h0,      32'h0312_3456, 8'hB4, 0);
        tbl[5]  = mk(1, 32'h0,         0, 24'h000111, 32'h0,         8'hB4, 1);
        tbl[6]  = mk(1, 32'h0,         0, 24'h000222, 32'h0,         8'hB4, 1);
        tbl[7]  = mk(0, 32'h0200_0000, 0, 24'h0,      32'h0200_0003, 8'hB4, 1);
        tbl[8]  = mk(0, 32'h8200_0002, 0, 24'h0,      32'h0200_0001, 8'hB4, 1);
        tbl[9]  = mk(0, 32'h7F00_0000, 0, 24'h0,      32'h7FDE_AD00, 8'hB4, 1);
        tbl[10] = mk(0, 32'h0200_0000, 0, 24'h0,      32'h0200_0005, 8'hB4, 1);
        tbl[11] = mk(0, 32'h0300_0000, 1, 24'h0ABCDE, 32'h0300_0222, 8'hB4, 1);
        tbl[12] = mk(0, 32'h0200_0000, 0, 24'h0,      32'h0200_0005, 8'hB4, 1);
        tbl[13] = mk(0, 32'h0300_0000, 0, 24'h0,      32'h030A_BCDE, 8'hB4, 0);
        tbl[14] = mk(0, 32'h0200_0000, 0, 24'h0,      32'h0200_0004, 8'hB4, 0);
        tbl[15] = mk(0, 32'h8200_0004, 0, 24'h0,      32'h0200_0000, 8'hB4, 0);
        tbl[16] = mk(0, 32'h84AB_CDEF, 0, 24'h0,      32'h04AB_CDEF, 8'hB4, 0);
        tbl[17] = mk(0, 32'h0400_0000, 0, 24'h0,      32'h04AB_CDEF, 8'hB4, 0);
        tbl[18] = mk(0, 32'h8012_3456, 0, 24'h0,      32'h0018_0A01, 8'hB4, 0);
        tbl[19] = mk(0, 32'h0200_0000, 0, 24'h0,      32'h0200_0000, 8'hB4, 0);
        tbl[20] = mk(0, 32'h81FF_FF00, 0, 24'h0,      32'h0100_0000, 8'h00, 0);
        tbl[21] = mk(0, 32'h8555_5555, 0, 24'h0,      32'h05DE_AD00, 8'h00, 0);
        tbl[22] = mk(0, 32'h83FF_FFFF, 0, 24'h0,      32'h030A_BCDE, 8'h00, 0);
        tbl[23] = mk(0, 32'h8200_0004, 1, 24'h000333, 32'h0200_0001, 8'h00, 1);

        // ---- reset ----
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tx_dv", {31'd0, tx_dv}, 32'd0);
        check("rst_tx_word", tx_word, 32'd0);
        check_outputs("rst", 8'h00, 0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---- directed table ----
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].is_adc) begin
                adc_pulse(tbl[i].adc_d);
                model_adc(tbl[i].adc_d);
            end else begin
                model_cmd(tbl[i].cmd, tbl[i].adc_same, tbl[i].adc_d, e);
                send_cmd(tbl[i].cmd, tbl[i].adc_same, tbl[i].adc_d, rsp);
                check($sformatf("tbl%0d_rsp", i), rsp, tbl[i].exp_tx);
            end
            @(negedge clk);
            check_outputs($sformatf("tbl%0d", i), tbl[i].exp_ctrl, tbl[i].exp_irq);
        end

        // ---- randomized commands against the model ----
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ad = 24'($urandom);
                adc_pulse(ad);
                model_adc(ad);
            end
            case ($urandom_range(0, 6))
                0: a = 7'h00;
                1: a = 7'h01;
                2: a = 7'h02;
                3: a = 7'h03;
                4: a = 7'h04;
                5: a = 7'($urandom_range(5, 127));
                default: a = 7'h02;
            endcase
            wr = ($urandom_range(0, 1) == 1);
            wd = 24'($urandom);
`ifdef SPI_WDOG_EN
            if (wr && a == 7'h01) wd[0] = 1'b0;
`endif
            same = ($urandom_range(0, 4) == 0);
            ad = 24'($urandom);
            cmd = {wr, a, wd};
            model_cmd(cmd, same, ad, e);
            exp_q.push_back(e);
            send_cmd(cmd, same, ad, rsp);
            check("rand_rsp", rsp, exp_q.pop_front());
            check_outputs("rand", m_ctrl, m_sv);
        end

        // ---- command strobe while busy is dropped and flags cmd_err ----
        model_cmd(32'h0400_0000, 0, 24'h0, e);
        m_err = 1;
        @(posedge clk); #1;
        rx_dv = 1'b1; rx_word = 32'h0400_0000;
        @(posedge clk); #1;
        rx_word = 32'h8400_0055;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        @(negedge clk);
        check("drop_tx_dv", {31'd0, tx_dv}, 32'd1);
        check("drop_rsp", tx_word, e);
        repeat (2) @(negedge clk);
        model_cmd(32'h0400_0000, 0, 24'h0, e);
        send_cmd(32'h0400_0000, 0, 24'h0, rsp);
        check("drop_scratch", rsp, e);
        model_cmd(32'h0200_0000, 0, 24'h0, e);
        send_cmd(32'h0200_0000, 0, 24'h0, rsp);
        check("drop_status", rsp, e);
        check("drop_err_bit", {31'd0, rsp[2]}, 32'd1);

`ifdef SPI_WDOG_EN
        // ---- watchdog: ADC enable falls 16 cycles after it is set ----
        @(posedge clk); #1;
        rx_dv = 1'b1; rx_word = 32'h8100_0001;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (adc_en) n++;
        end
        check("wdog_en_cycles", n, 32'd16);
        check("wdog_en_low", {31'd0, adc_en}, 32'd0);
        m_ctrl = 8'h00;
        m_wd = 1;
        model_cmd(32'h0200_0000, 0, 24'h0, e);
        send_cmd(32'h0200_0000, 0, 24'h0, rsp);
        check("wdog_status", rsp, e);
        check("wdog_trip_bit", {31'd0, rsp[3]}, 32'd1);
        model_cmd(32'h8200_0008, 0, 24'h0, e);
        send_cmd(32'h8200_0008, 0, 24'h0, rsp);
        check("wdog_w1c", rsp, e);
`endif

        // ---- reset in the decode cycle: command discarded ----
        adc_pulse(24'h00ABCD);
        model_adc(24'h00ABCD);
        model_cmd(32'h8100_00F4, 0, 24'h0, e);
        send_cmd(32'h8100_00F4, 0, 24'h0, rsp);
        check("pre_rst_ctrl", rsp, e);
        @(posedge clk); #1;
        rx_dv = 1'b1; rx_word = 32'h0400_0000;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        check("pre_rst_state", {30'd0, dbg_state}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_tx_word", tx_word, 32'd0);
        check_outputs("mid_rst", 8'h00, 0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (tx_dv) n++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (tx_dv) n++;
        end
        check("mid_rst_no_tx", n, 32'd0);
        model_cmd(32'h0400_0000, 0, 24'h0, e);
        send_cmd(32'h0400_0000, 0, 24'h0, rsp);
        check("post_rst_scratch", rsp, e);
        model_cmd(32'h0200_0000, 0, 24'h0, e);
        send_cmd(32'h0200_0000, 0, 24'h0, rsp);
        check("post_rst_status", rsp, e);

        // ---- report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command controller between the 32-bit SPI slave word interface and the voltmeter ADC core.
- Decodes each received SPI word as a register read/write command, maintains a small register file (ID, control, status, sample, scratch) and drives ADC configuration.
- Captures ADC samples; loads the response word into the SPI slave TX path so it shifts out during the next SPI word.

Parameters:
- DEV_ID, 24'h180_A01, read-only identification value at address 0x00.
- WDOG_CYCLES, 1_000_000, i_Clk cycles without a valid command before watchdog trips (used only with SPI_WDOG_EN).

Ports:
- i_Clk  in  1  system clock; same clock as the SPI slave's i_Clk.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_RX_DV  in  1  one-cycle pulse: i_RX_Word valid (from slave o_RX_DV).
- i_RX_Word  in  32  received command word (from slave o_RX_Byte).
- o_TX_DV  out  1  one-cycle pulse: load o_TX_Word into slave (to i_TX_DV).
- o_TX_Word  out  32  response word (to slave i_TX_Byte).
- i_ADC_Valid  in  1  one-cycle pulse: new conversion on i_ADC_Data.
- i_ADC_Data  in  24  conversion result.
- o_ADC_En  out  1  ADC enable (CTRL[0]).
- o_ADC_Gain  out  3  gain select (CTRL[3:1]).
- o_ADC_Rate  out  4  rate select (CTRL[7:4]).
- o_Sample_Irq  out  1  high while an unread sample is held (STATUS[0]).

Behaviour:
- Command word: [31]=1 write / 0 read; [30:24] address; [23:0] write data (ignored on reads).
- Response word: {1'b0, addr[6:0], data[23:0]}; data = register value after the command takes effect (writes echo the stored value).
- Register map:
  - 0x00 ID: RO, DEV_ID.
  - 0x01 CTRL: RW, bits[7:0]; upper bits read 0.
  - 0x02 STATUS: [0] sample_valid, [1] overrun, [2] cmd_err. Bits 1 and 2 are W1C. Bit 0 is RO.
  - 0x03 SAMPLE: RO, 24-bit latched sample; reading clears sample_valid.
  - 0x04 SCRATCH: RW, 24 bits.
  - Any other address: write ignored; response data 24'hDEAD00; cmd_err set.
- Writes to RO addresses are ignored (not an error).
- FSM IDLE -> DECODE -> RESPOND -> IDLE:
  - IDLE: on i_RX_DV, latch i_RX_Word, go to DECODE.
  - DECODE: perform the register access.
  - RESPOND: drive o_TX_DV=1 for one cycle with o_TX_Word.
  - o_TX_DV therefore rises 2 cycles after i_RX_DV.
  - An i_RX_DV arriving while not in IDLE is dropped and sets cmd_err (cannot happen at legal SPI rates).
- Sample capture: on i_ADC_Valid, SAMPLE <= i_ADC_Data and sample_valid <= 1. If sample_valid was already 1, overrun <= 1 (data still overwritten).
- Simultaneous i_ADC_Valid and a SAMPLE read in DECODE: the response returns the old sample, SAMPLE takes the new value, sample_valid stays 1, overrun is not set.
- Simultaneous W1C clear and a new set event: set wins.
- Reset values:
  - FSM IDLE; o_TX_DV=0; o_TX_Word=0.
  - CTRL=0, so o_ADC_En=0, o_ADC_Gain=0, o_ADC_Rate=0.
  - STATUS=0; o_Sample_Irq=0; SAMPLE=0; SCRATCH=0.
- Reset mid-command: the command is discarded and no o_TX_DV is issued.
- All outputs are registered.

Optional Feature:
- SPI_WDOG_EN defined:
  - Counter increments each i_Clk while CTRL[0]=1 and reloads to 0 on every i_RX_DV.
  - On reaching WDOG_CYCLES-1: CTRL[0] cleared (ADC disabled), STATUS[3] wdog_trip set (W1C), counter held at 0.
  - Counter is idle while CTRL[0]=0.
- Undefined: no counter; STATUS[3] reads 0; CTRL changes only by SPI writes.

Decomposition:
- Package spi_reg_pkg holds:
  - Address constants ADDR_ID..ADDR_SCRATCH.
  - Status bit indices.
  - Command field positions (CMD_WR_BIT, ADDR_MSB/LSB).
  - FSM state enum.
  - Error pattern 24'hDEAD00.
- One natural sub-module: spi_reg_wdog (counter plus trip pulse), instantiated only under SPI_WDOG_EN.

Test Plan:
- Reset, then read 0x00 (word 0x0000_0000) -> o_TX_DV exactly 2 cycles after i_RX_DV, o_TX_Word=0x0018_0A01.
- Write CTRL 0x8100_00B5 -> o_ADC_En=1, o_ADC_Gain=3'b010, o_ADC_Rate=4'hB; response 0x0100_00B5.
- i_ADC_Valid with 0x12_3456 -> o_Sample_Irq=1; read 0x03 -> response 0x0312_3456, o_Sample_Irq=0.
- Two ADC pulses without a read -> STATUS reads 0x000003; write 0x8200_0002 -> STATUS 0x000001.
- Read address 0x7F -> response 0x7FDE_AD00, STATUS[2]=1; same-cycle ADC pulse and SAMPLE read -> old data returned, sample_valid stays 1.
- SPI_WDOG_EN with WDOG_CYCLES=16: enable, no further commands -> o_ADC_En falls 16 cycles later, STATUS[3]=1; assert i_Rst_L=0 mid-DECODE -> no o_TX_DV, all outputs zero.
